// File: rtl/instruction_fetch_unit.sv
// PC register and fetch stage feeding a combinational program ROM; registers the word for decode via valid/ready.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets fault instead of being word-aligned.
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Target_i,
  input  logic                  Ready_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic                  Fault_o
);

  localparam logic [DATA_WIDTH-1:0] ROM_SPAN  = DATA_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [DATA_WIDTH-1:0] pc_out_reg;
  logic                  valid_reg;
  logic                  fault_reg;

  logic                  in_range;
  logic                  load;
  logic [DATA_WIDTH-1:0] target_pc;
  logic                  target_misaligned;

  // Subtraction only happens once pc_reg >= BASE_ADDR, so no wrap can sneak a low PC into range.
  assign in_range = (pc_reg >= BASE_ADDR) && ((pc_reg - BASE_ADDR) < ROM_SPAN);
  assign load     = !valid_reg || Ready_i;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc         = Target_i;
  assign target_misaligned = |Target_i[1:0];
`else
  assign target_pc         = Target_i & WORD_MASK;
  assign target_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= FETCH;
      pc_reg     <= BASE_ADDR;
      instr_reg  <= '0;
      pc_out_reg <= '0;
      valid_reg  <= 1'b0;
      fault_reg  <= 1'b0;
    end else if (Redirect_i) begin
      // Flush wins over a same-cycle handshake; stale instr/pc stay visible under Valid_o=0.
      pc_reg    <= target_pc;
      valid_reg <= 1'b0;
      if (target_misaligned) begin
        fault_reg <= 1'b1;
        state_reg <= FAULT;
      end else begin
        fault_reg <= 1'b0;
        state_reg <= FETCH;
      end
    end else begin
      case (state_reg)
        FETCH, STALL: begin
          if (!load) begin
            state_reg <= STALL;
          end else if (in_range) begin
            instr_reg  <= Instruction_i;
            pc_out_reg <= pc_reg;
            valid_reg  <= 1'b1;
            pc_reg     <= pc_reg + PC_STEP;
            state_reg  <= FETCH;
          end else begin
            valid_reg <= 1'b0;
            fault_reg <= 1'b1;
            state_reg <= FAULT;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          fault_reg <= 1'b1;
        end
      endcase
    end
  end

  assign Address_o     = pc_reg;
  assign Valid_o       = valid_reg;
  assign Instruction_o = instr_reg;
  assign PC_o          = pc_out_reg;
  assign Fault_o       = fault_reg;

endmodule
